apb_slave: RTL and testbench
============================

# apb_slave

APB3 completer that answers the transfers issued by `apb_master`. It holds a bank of 32-bit registers, inserts a fixed number of wait states, and signals PSLVERR for illegal accesses. It serves as the register-mapped endpoint behind the interconnect and as the standard responder in master-level benches.

## Interface
Parameters:
- ADDR_WIDTH, 32, PADDR width
- DATA_WIDTH, 32, PWDATA/PRDATA width
- NUM_REGS, 16, number of registers (power of two, ≥2)
- BASE_ADDR, 32'h0000_0000, byte address of register 0
- WAIT_STATES, 2, wait cycles inserted before PREADY (0..15)
- ID_VALUE, 32'hA5B0_0001, read-only content of register 0

Ports:
- PCLK  input  1  clock; all logic on rising edge
- PRESET  input  1  reset; one clock, synchronous, active-high
- PSEL  input  1  select
- PENABLE  input  1  access phase
- PWRITE  input  1  1 = write, 0 = read
- PADDR  input  ADDR_WIDTH  byte address
- PWDATA  input  DATA_WIDTH  write data
- PRDATA  output  DATA_WIDTH  read data, registered
- PREADY  output  1  transfer complete, registered
- PSLVERR  output  1  error response, registered, valid only with PREADY

## Operation
- Register map:
  - Register i sits at BASE_ADDR + 4*i.
  - Register 0 = ID_VALUE, read-only.
  - Registers 1..NUM_REGS-1 are read/write and reset to 0.
- Error conditions, checked on the latched setup address:
  - PADDR[1:0] != 0.
  - Offset (PADDR - BASE_ADDR) ≥ 4*NUM_REGS, or PADDR < BASE_ADDR.
  - Write to register 0.
- An errored access responds with PSLVERR=1 and PRDATA=0. A write that errors changes no state.
- FSM states: IDLE, WAIT, RESP.
  - IDLE:
    - PSEL=1 and PENABLE=0 (setup phase): latch PADDR, PWRITE and PWDATA, decode the error, load the wait counter with WAIT_STATES.
    - Next state is RESP if WAIT_STATES=0, else WAIT.
  - WAIT:
    - Counter decrements each cycle.
    - On the cycle the counter reaches 1, go to RESP.
  - RESP:
    - PREADY=1 and PSLVERR is valid. For reads, PRDATA is valid.
    - At the edge where PSEL&PENABLE&PREADY=1, writes commit and the FSM returns to IDLE.
  - Entry to RESP registers PREADY=1, PSLVERR and PRDATA, so all three are valid in the same cycle.
- Abort:
  - PSEL=0 in WAIT or RESP sends the FSM to IDLE at the next edge.
  - No write commits; PREADY and PSLVERR are 0 in the following cycle.
- PENABLE=0 while PSEL=1 in WAIT or RESP is treated as a new setup: re-latch the transfer and restart the count.
- PSEL=1 and PENABLE=1 in IDLE (no setup seen) is ignored: no PREADY.
- PWDATA and PWRITE are taken from the setup-phase latch. Changes during the access phase are ignored.

## Timing
- Reset values: PREADY=0, PSLVERR=0, PRDATA=0, FSM=IDLE, registers 1..NUM_REGS-1 = 0.
- Reset mid-transfer: the transfer is dropped, no write occurs, and all outputs are at reset values the next cycle.
- Setup in cycle T puts PREADY high in cycle T+1+WAIT_STATES.
  - WAIT_STATES=0 gives the zero-wait APB transfer: completion in T+1.
- PREADY is high for exactly one cycle per completed transfer. It is 0 in every other cycle.
- Write data is visible to a read whose setup occurs in the cycle after completion.
- Back-to-back: a setup in the cycle right after completion is accepted with no idle gap.
- PSLVERR is 0 whenever PREADY is 0.
- PRDATA holds its last value outside RESP. Checkers must sample it only with PREADY=1.

## Test plan
- Reset, then read 0x00 → PREADY in setup+3 cycles (WAIT_STATES=2), PRDATA=0xA5B00001, PSLVERR=0.
- Write 0xDEADBEEF to 0x04, then read 0x04 back-to-back → PRDATA=0xDEADBEEF; PREADY high exactly 1 cycle each transfer.
- Write 0x1234 to 0x00, then read 0x00 → write responds PSLVERR=1, read returns 0xA5B00001.
- Read 0x40 (out of range) and read 0x06 (misaligned) → PSLVERR=1, PRDATA=0. Writes to either → PSLVERR=1, all registers unchanged.
- Abort: write 0x55 to 0x08, drop PSEL during the wait → no PREADY; a later read of 0x08 returns 0.
- Assert PRESET during a wait after writing 0x77 to 0x0C → outputs 0 next cycle; a read of 0x0C returns 0. Repeat with WAIT_STATES=0 → PREADY in the cycle after setup.

Source files
------------

// File: rtl/apb_slave.sv
// APB3 completer: a bank of 32-bit registers behind a fixed-latency handshake.
// Register 0 is a read-only ID word. The remaining registers are read/write.
// Misaligned, out-of-window and register-0 writes answer with PSLVERR.
module apb_slave #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 2,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(32'hA5B0_0001)
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int                    IDX_W = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(4 * NUM_REGS);
    localparam logic [3:0]            WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    wr_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   prdata_q;
    logic                    pready_q;
    logic                    pslverr_q;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];

    logic                    setup;
    logic [ADDR_WIDTH-1:0]   offset;
    logic [IDX_W-1:0]        setup_idx;
    logic                    setup_err;
    logic [DATA_WIDTH-1:0]   setup_rdata;
    logic [DATA_WIDTH-1:0]   resp_rdata;

    // Decode the live setup-phase address and the response data for both the
    // zero-wait path (straight from the bus) and the waited path (latched).
    always_comb begin
        setup       = PSEL && !PENABLE;
        offset      = PADDR - BASE_ADDR;
        setup_idx   = offset[IDX_W+1:2];
        setup_err   = (PADDR[1:0] != 2'b00) || (PADDR < BASE_ADDR) ||
                      (offset >= SPAN) || (PWRITE && (setup_idx == '0));
        setup_rdata = setup_err ? '0 : regs_q[setup_idx];
        resp_rdata  = err_q ? '0 : regs_q[idx_q];
    end

    // Transfer FSM with registered PREADY/PSLVERR/PRDATA and the register bank.
    // Any setup phase (PSEL & !PENABLE) restarts the transfer, whatever the state.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= (i == 0) ? ID_VALUE : '0;
        end else begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            if (setup) begin
                idx_q   <= setup_idx;
                wr_q    <= PWRITE;
                err_q   <= setup_err;
                wdata_q <= PWDATA;
                cnt_q   <= WS;
                if (WAIT_STATES == 0) begin
                    state_q   <= S_RESP;
                    pready_q  <= 1'b1;
                    pslverr_q <= setup_err;
                    prdata_q  <= setup_rdata;
                end else begin
                    state_q <= S_WAIT;
                end
            end else begin
                case (state_q)
                    S_WAIT: begin
                        if (!PSEL) begin
                            state_q <= S_IDLE;
                        end else if (cnt_q <= 4'd1) begin
                            state_q   <= S_RESP;
                            pready_q  <= 1'b1;
                            pslverr_q <= err_q;
                            prdata_q  <= resp_rdata;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                    S_RESP: begin
                        // PSEL & PENABLE here (setup handled above): commit unless aborted
                        if (PSEL && wr_q && !err_q)
                            regs_q[idx_q] <= wdata_q;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave.sv
// Bench for apb_slave: two instances (base 0 / 2 wait states, and
// base 0x100 / zero wait states) driven by directed and random transfers,
// checked against a register-array reference model.
module tb_apb_slave;

    localparam logic [31:0] ID = 32'hA5B0_0001;

    logic        clk = 1'b0;
    logic        rst     [2];
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [31:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    logic [31:0] mdl [2][16];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    apb_slave #(.BASE_ADDR(32'h0), .WAIT_STATES(2)) u_dut_ws2 (
        .PCLK(clk), .PRESET(rst[0]), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

    apb_slave #(.BASE_ADDR(32'h100), .WAIT_STATES(0)) u_dut_ws0 (
        .PCLK(clk), .PRESET(rst[1]), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic mreset(input int d);
        for (int i = 0; i < 16; i++) mdl[d][i] = (i == 0) ? ID : 32'h0;
    endtask

    task automatic chk_zero_outs(input int d, input string tag);
        chk({tag, "_rdy"}, 32'(pready[d]), 32'd0);
        chk({tag, "_err"}, 32'(pslverr[d]), 32'd0);
        chk({tag, "_rdata"}, prdata[d], 32'd0);
    endtask

    // One APB transfer. abort_at / rst_at pick the cycle after setup (1-based)
    // at which PSEL is dropped or PRESET is pulsed; 0 disables.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input int abort_at, input int rst_at,
                        input bit b2b);
        int          ws;
        logic [31:0] base, off, exp_rd;
        bit          err, done;
        int          idx;
        ws     = (d == 0) ? 2 : 0;
        base   = (d == 0) ? 32'h0 : 32'h100;
        off    = addr - base;
        err    = (addr[1:0] != 2'b00) || (addr < base) || (off >= 32'd64) ||
                 (wr && off == 32'd0);
        idx    = int'(off[5:2]);
        exp_rd = err ? 32'h0 : mdl[d][idx];
        done   = 1'b0;
        if (!b2b) begin
            @(posedge clk); #1;
            psel[d] = 1'b0; penable[d] = 1'b0;
            chk("idle_rdy", 32'(pready[d]), 32'd0);
        end
        @(posedge clk); #1;
        chk("pulse_rdy", 32'(pready[d]), 32'd0);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
        paddr[d] = addr; pwdata[d] = wd;
        for (int n = 1; n <= 40 && !done; n++) begin
            @(posedge clk); #1;
            if (n == rst_at) begin
                rst[d] = 1'b1; psel[d] = 1'b0; penable[d] = 1'b0;
                @(posedge clk); #1;
                rst[d] = 1'b0;
                chk_zero_outs(d, "rst");
                mreset(d);
                done = 1'b1;
            end else if (n == abort_at) begin
                psel[d] = 1'b0; penable[d] = 1'b0;
                chk("abort_rdy", 32'(pready[d]), 32'(n == 1 + ws));
                @(posedge clk); #1;
                chk("post_abort_rdy", 32'(pready[d]), 32'd0);
                chk("post_abort_err", 32'(pslverr[d]), 32'd0);
                done = 1'b1;
            end else begin
                // access-phase changes to PWRITE/PWDATA must be ignored
                penable[d] = 1'b1; pwrite[d] = ~wr; pwdata[d] = ~wd;
                if (pready[d]) begin
                    chk("latency", 32'(n), 32'(1 + ws));
                    chk("slverr", 32'(pslverr[d]), 32'(err));
                    if (!wr || err) chk("rdata", prdata[d], exp_rd);
                    if (wr && !err) mdl[d][idx] = wd;
                    done = 1'b1;
                end else begin
                    chk("err_wo_rdy", 32'(pslverr[d]), 32'd0);
                end
            end
        end
        chk("timeout", 32'(done), 32'd1);
    endtask

    // PSEL & PENABLE with no preceding setup must never be answered.
    task automatic no_setup(input int d);
        @(posedge clk); #1;
        psel[d] = 1'b1; penable[d] = 1'b1; pwrite[d] = 1'b0;
        paddr[d] = (d == 0) ? 32'h0 : 32'h100;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            chk("nosetup_rdy", 32'(pready[d]), 32'd0);
        end
        psel[d] = 1'b0; penable[d] = 1'b0;
    endtask

    function automatic logic [31:0] rnd_addr(input int d);
        logic [31:0] base;
        int          r;
        base = (d == 0) ? 32'h0 : 32'h100;
        r    = $urandom_range(0, 9);
        if (r <= 6)      return base + 32'(4 * $urandom_range(0, 15));
        else if (r == 7) return base + 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
        else if (r == 8) return base + 32'h40 + 32'(4 * $urandom_range(0, 31));
        else if (d == 1) return base - 32'(4 * $urandom_range(1, 8));
        else             return base + 32'h1000;
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = 32'h0; pwdata[d] = 32'h0;
            mreset(d);
        end
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        chk_zero_outs(0, "por0");
        chk_zero_outs(1, "por1");

        // base 0, two wait states
        xfer(0, 0, 32'h00, 32'h0, 0, 0, 0);
        chk("id_model", mdl[0][0], ID);
        xfer(0, 1, 32'h04, 32'hDEAD_BEEF, 0, 0, 0);
        xfer(0, 0, 32'h04, 32'h0, 0, 0, 1);
        xfer(0, 1, 32'h00, 32'h1234, 0, 0, 0);
        xfer(0, 0, 32'h00, 32'h0, 0, 0, 1);
        xfer(0, 0, 32'h40, 32'h0, 0, 0, 0);
        xfer(0, 0, 32'h06, 32'h0, 0, 0, 0);
        xfer(0, 1, 32'h40, 32'hFFFF_FFFF, 0, 0, 0);
        xfer(0, 1, 32'h06, 32'hFFFF_FFFF, 0, 0, 0);
        xfer(0, 0, 32'h04, 32'h0, 0, 0, 0);
        xfer(0, 1, 32'h08, 32'h55, 2, 0, 0);
        xfer(0, 0, 32'h08, 32'h0, 0, 0, 0);
        xfer(0, 1, 32'h08, 32'h66, 3, 0, 0);
        xfer(0, 0, 32'h08, 32'h0, 0, 0, 0);
        xfer(0, 0, 32'h00, 32'h0, 0, 0, 0);
        xfer(0, 1, 32'h0C, 32'h77, 0, 1, 0);
        xfer(0, 0, 32'h0C, 32'h0, 0, 0, 0);
        no_setup(0);

        // base 0x100, zero wait states
        xfer(1, 0, 32'h100, 32'h0, 0, 0, 0);
        xfer(1, 1, 32'h104, 32'hDEAD_BEEF, 0, 0, 0);
        xfer(1, 0, 32'h104, 32'h0, 0, 0, 1);
        xfer(1, 0, 32'h0FC, 32'h0, 0, 0, 0);
        xfer(1, 1, 32'h100, 32'h1234, 0, 0, 1);
        xfer(1, 0, 32'h100, 32'h0, 0, 0, 1);
        xfer(1, 1, 32'h10C, 32'h77, 0, 1, 0);
        xfer(1, 0, 32'h10C, 32'h0, 0, 0, 0);
        no_setup(1);

        // random traffic on both instances
        for (int k = 0; k < 400; k++) begin
            int  d, ab;
            bit  wr;
            d  = k % 2;
            wr = 1'($urandom_range(0, 1));
            ab = 0;
            if ($urandom_range(0, 9) == 0) ab = (d == 0) ? $urandom_range(1, 3) : 1;
            xfer(d, wr, rnd_addr(d), $urandom, ab, 0, 1'($urandom_range(0, 1)));
        end

        // read back every register of both instances
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++)
                xfer(d, 0, ((d == 0) ? 32'h0 : 32'h100) + 32'(4 * i), 32'h0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
